// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the multi-port register file slice.
//   - RF_DATA_W / RF_ADDR_W : default register width and address width
//   - clr_state_e           : scrub engine states
//   - rf_depth()            : entry count for a given address width
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_e;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// ---------------------------------------------------------------------------
// regfile_clr_fsm
//   Sequential scrub engine for the register file. When idle and i_clr_req
//   is seen at a clock edge, it walks every entry index from 0 to DEPTH-1,
//   one per cycle, then emits a single-cycle done pulse and returns to idle.
//
// Ports
//   i_clk       in   1       clock, rising edge
//   i_rst_n     in   1       asynchronous active-low reset
//   i_clr_req   in   1       scrub request, sampled only in CLR_IDLE
//   o_clr_busy  out  1       scrub in progress (registered)
//   o_clr_done  out  1       one-cycle pulse after the last entry is cleared
//   o_clr_en    out  1       clear strobe: entry o_clr_idx is zeroed this edge
//   o_clr_idx   out  ADDR_W  entry being cleared this cycle
// ---------------------------------------------------------------------------
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic              o_clr_en,
    output logic [ADDR_W-1:0] o_clr_idx
);

    clr_state_e        state;
    logic [ADDR_W-1:0] idx;
    logic              busy;
    logic              done;

    // State, index and both status outputs are registered together so that
    // busy/done change exactly on the edge that moves the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= CLR_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    done <= 1'b0;
                    if (i_clr_req) begin
                        state <= CLR_RUN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    // The last index is cleared on this edge; DEPTH busy
                    // cycles in total, then the done pulse.
                    if (idx == '1) begin
                        state <= CLR_DONE;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                CLR_DONE: begin
                    // Requests are not sampled here; IDLE sees them next.
                    state <= CLR_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= CLR_IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_busy = busy;
    assign o_clr_done = done;
    assign o_clr_en   = busy;
    assign o_clr_idx  = idx;

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port integer register file for the decode stage.
//   NUM_WR write ports (driven by writeback lanes), NUM_RD combinational read
//   ports, optional hard-wired zero entry, and a sequential scrub engine that
//   clears every entry on request.
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   : a write landing on a read address this cycle is forwarded
//                 to that read port in the same cycle
//     undefined : reads return stored contents only
//
// Ports
//   i_clk       in   1                 clock, rising edge
//   i_rst_n     in   1                 asynchronous active-low reset
//   i_rs_addr   in   NUM_RD x ADDR_W   read addresses
//   o_rs_data   out  NUM_RD x DATA_W   read data (combinational)
//   i_rd_wren   in   NUM_WR            per-port write enable
//   i_rd_addr   in   NUM_WR x ADDR_W   write addresses
//   i_rd_data   in   NUM_WR x DATA_W   write data
//   i_clr_req   in   1                 start scrub (sampled while idle)
//   o_clr_busy  out  1                 scrub in progress
//   o_clr_done  out  1                 one-cycle pulse after scrub completes
// ---------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  i_rs_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  o_rs_data,
    input  logic [NUM_WR-1:0]              i_rd_wren,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  i_rd_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  i_rd_data,
    input  logic                           i_clr_req,
    output logic                           o_clr_busy,
    output logic                           o_clr_done
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DEPTH-1:0]  ent_we;
    logic [DATA_W-1:0] ent_wd [DEPTH];

    logic              clr_busy;
    logic              clr_done;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_idx;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr_req  (i_clr_req),
        .o_clr_busy (clr_busy),
        .o_clr_done (clr_done),
        .o_clr_en   (clr_en),
        .o_clr_idx  (clr_idx)
    );

    assign o_clr_busy = clr_busy;
    assign o_clr_done = clr_done;

    // Per-entry write resolve. Ports are scanned in ascending order so that
    // the highest-index port targeting an entry overwrites lower ones. All
    // writes are blocked while the scrub engine owns the array, and entry 0
    // never takes a write when it is the hard-wired zero.
    always_comb begin
        ent_we = '0;
        for (int e = 0; e < DEPTH; e++) begin
            ent_wd[e] = '0;
        end
        if (!clr_busy) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (i_rd_wren[p]) begin
                    ent_we[i_rd_addr[p]] = 1'b1;
                    ent_wd[i_rd_addr[p]] = i_rd_data[p];
                end
            end
        end
        if (ZERO_REG) begin
            ent_we[0] = 1'b0;
            ent_wd[0] = '0;
        end
    end

    // Storage array: reset and scrub clear take priority over writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (clr_en && (clr_idx == ADDR_W'(e))) begin
                    mem[e] <= '0;
                end else if (ent_we[e]) begin
                    mem[e] <= ent_wd[e];
                end
            end
        end
    end

    // Read muxes. The zero-entry override is applied last so it also masks
    // any forwarded value.
    always_comb begin
        o_rs_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            o_rs_data[r] = mem[i_rs_addr[r]];
`ifdef RF_BYPASS_EN
            if (ent_we[i_rs_addr[r]]) begin
                o_rs_data[r] = ent_wd[i_rs_addr[r]];
            end
`endif
            if (ZERO_REG && (i_rs_addr[r] == '0)) begin
                o_rs_data[r] = '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Self-checking bench for regfile_mp with default parameters
//   (DATA_W=32, ADDR_W=5, NUM_RD=2, NUM_WR=2, ZERO_REG=1). Expected read
//   values for same-cycle write/read follow RF_BYPASS_EN when defined.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DEPTH = 32;

    logic             clk;
    logic             rst_n;
    logic [1:0][4:0]  rs_addr;
    logic [1:0][31:0] rs_data;
    logic [1:0]       wren;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;

    int checks;
    int errors;

    regfile_mp dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rs_addr  (rs_addr),
        .o_rs_data  (rs_data),
        .i_rd_wren  (wren),
        .i_rd_addr  (wr_addr),
        .i_rd_data  (wr_data),
        .i_clr_req  (clr_req),
        .o_clr_busy (clr_busy),
        .o_clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0_nb;
        logic [31:0] e1_nb;
        logic [31:0] e0_by;
        logic [31:0] e1_by;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock: rising edge, then back to the falling edge where
    // the next inputs are driven.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wren    = 2'b00;
        wr_addr = '0;
        wr_data = '0;
        rs_addr = '0;
    endtask

    logic [31:0] e0, e1;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        clr_req = 1'b0;
        idle_inputs();

        //            we     wa0    wd0           wa1    wd1           ra0    ra1    e0_nb         e1_nb         e0_by         e1_by
        vt[0] = '{2'b11, 5'd1, 32'hDEADBEEF, 5'd2, 32'hCAFEBABE, 5'd1, 5'd2, 32'h0,        32'h0,        32'hDEADBEEF, 32'hCAFEBABE};
        vt[1] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd1, 5'd2, 32'hDEADBEEF, 32'hCAFEBABE, 32'hDEADBEEF, 32'hCAFEBABE};
        vt[2] = '{2'b11, 5'd5, 32'h11111111, 5'd5, 32'h22222222, 5'd5, 5'd1, 32'h0,        32'hDEADBEEF, 32'h22222222, 32'hDEADBEEF};
        vt[3] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd5, 5'd2, 32'h22222222, 32'hCAFEBABE, 32'h22222222, 32'hCAFEBABE};
        vt[4] = '{2'b01, 5'd0, 32'h0BADCAFE, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
        vt[5] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd0, 5'd5, 32'h0,        32'h22222222, 32'h0,        32'h22222222};
        vt[6] = '{2'b10, 5'd0, 32'h0,        5'd3, 32'h12345678, 5'd3, 5'd3, 32'h0,        32'h0,        32'h12345678, 32'h12345678};
        vt[7] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd3, 5'd1, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        vt[8] = '{2'b11, 5'd1, 32'hAAAA0001, 5'd0, 32'h55555555, 5'd1, 5'd0, 32'hDEADBEEF, 32'h0,        32'hAAAA0001, 32'h0};
        vt[9] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd1, 5'd0, 32'hAAAA0001, 32'h0,        32'hAAAA0001, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rs_addr[0] = 5'd1;
        rs_addr[1] = 5'd31;
        #1;
        chk("rst_busy", {31'b0, clr_busy}, 32'h0);
        chk("rst_done", {31'b0, clr_done}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_rd_x1", rs_data[0], 32'h0);
        chk("rst_rd_x31", rs_data[1], 32'h0);
        step();

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            wren       = vt[i].we;
            wr_addr[0] = vt[i].wa0;
            wr_data[0] = vt[i].wd0;
            wr_addr[1] = vt[i].wa1;
            wr_data[1] = vt[i].wd1;
            rs_addr[0] = vt[i].ra0;
            rs_addr[1] = vt[i].ra1;
`ifdef RF_BYPASS_EN
            e0 = vt[i].e0_by;
            e1 = vt[i].e1_by;
`else
            e0 = vt[i].e0_nb;
            e1 = vt[i].e1_nb;
`endif
            #1;
            chk($sformatf("vec%0d_rs0", i), rs_data[0], e0);
            chk($sformatf("vec%0d_rs1", i), rs_data[1], e1);
            chk($sformatf("vec%0d_busy", i), {31'b0, clr_busy}, 32'h0);
            step();
        end
        idle_inputs();

        // Fill x1..x31 with their index
        for (int i = 1; i < DEPTH; i++) begin
            wren       = 2'b01;
            wr_addr[0] = 5'(i);
            wr_data[0] = 32'(i);
            step();
        end
        idle_inputs();
        rs_addr[0] = 5'd17;
        rs_addr[1] = 5'd31;
        #1;
        chk("fill_x17", rs_data[0], 32'd17);
        chk("fill_x31", rs_data[1], 32'd31);

        // Scrub request; the write in the request cycle still commits
        clr_req    = 1'b1;
        wren       = 2'b01;
        wr_addr[0] = 5'd2;
        wr_data[0] = 32'h22220000;
        step();
        clr_req = 1'b0;
        idle_inputs();

        for (int k = 0; k < DEPTH; k++) begin
            idle_inputs();
            e0 = 32'h0;
            e1 = 32'h0;
            if (k == 0) begin
                rs_addr[0] = 5'd2;  e0 = 32'h22220000;
                rs_addr[1] = 5'd31; e1 = 32'd31;
            end else if (k == 10) begin
                rs_addr[0] = 5'd9;  e0 = 32'h0;
                rs_addr[1] = 5'd20; e1 = 32'd20;
            end else if (k == 20) begin
                wren       = 2'b10;
                wr_addr[1] = 5'd7;
                wr_data[1] = 32'h77777777;
                rs_addr[0] = 5'd7;  e0 = 32'h0;
                rs_addr[1] = 5'd25; e1 = 32'd25;
            end
            #1;
            chk($sformatf("scrub_busy_c%0d", k), {31'b0, clr_busy}, 32'h1);
            chk($sformatf("scrub_done_c%0d", k), {31'b0, clr_done}, 32'h0);
            if (k == 0 || k == 10 || k == 20) begin
                chk($sformatf("scrub_rs0_c%0d", k), rs_data[0], e0);
                chk($sformatf("scrub_rs1_c%0d", k), rs_data[1], e1);
            end
            step();
        end
        idle_inputs();
        #1;
        chk("scrub_done_pulse", {31'b0, clr_done}, 32'h1);
        chk("scrub_busy_after", {31'b0, clr_busy}, 32'h0);
        step();
        #1;
        chk("scrub_done_low", {31'b0, clr_done}, 32'h0);

        // Every entry reads zero after the scrub, including x7 written while busy
        for (int a = 0; a < DEPTH; a += 2) begin
            rs_addr[0] = 5'(a);
            rs_addr[1] = 5'(a + 1);
            #1;
            chk($sformatf("post_scrub_x%0d", a), rs_data[0], 32'h0);
            chk($sformatf("post_scrub_x%0d", a + 1), rs_data[1], 32'h0);
        end
        @(negedge clk);

        // Writes accepted again after the scrub
        wren       = 2'b01;
        wr_addr[0] = 5'd9;
        wr_data[0] = 32'h99990009;
        step();
        idle_inputs();
        rs_addr[0] = 5'd9;
        #1;
        chk("post_scrub_write", rs_data[0], 32'h99990009);

        // Reset in the middle of a scrub
        wren       = 2'b11;
        wr_addr[0] = 5'd12;
        wr_data[0] = 32'h0C0C0C0C;
        wr_addr[1] = 5'd31;
        wr_data[1] = 32'h31313131;
        step();
        idle_inputs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
        end
        rs_addr[0] = 5'd12;
        rs_addr[1] = 5'd31;
        #1;
        chk("mid_busy_before", {31'b0, clr_busy}, 32'h1);
        chk("mid_x31_before", rs_data[1], 32'h31313131);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, clr_busy}, 32'h0);
        chk("mid_rst_done", {31'b0, clr_done}, 32'h0);
        chk("mid_rst_x12", rs_data[0], 32'h0);
        chk("mid_rst_x31", rs_data[1], 32'h0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        wren       = 2'b01;
        wr_addr[0] = 5'd12;
        wr_data[0] = 32'hABCD1234;
        step();
        idle_inputs();
        rs_addr[0] = 5'd12;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mid_after_x12_c%0d", k), rs_data[0], 32'hABCD1234);
            chk($sformatf("mid_after_done_c%0d", k), {31'b0, clr_done}, 32'h0);
            chk($sformatf("mid_after_busy_c%0d", k), {31'b0, clr_busy}, 32'h0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
